// File: rtl/accum_group_driver_if.sv
// Bundles every signal of accum_group_driver except clock and reset.
// master: the driver's view. slave: the view of the surrounding
// control/DMA layer, operand memory and accumulator.
interface accum_group_driver_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int TAG_WIDTH  = 8
);
  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;
  // Operand memory read port
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_rd_data;
  // Operand stream to the accumulator
  logic [WIDTH-1:0]      ip;
  logic                  valid_in;
  logic                  end_of_group;
  logic                  ready;
  // Result return from the accumulator
  logic                  valid_out;
  logic [WIDTH-1:0]      result;
  // Tagged result and status
  logic                  res_valid;
  logic [WIDTH-1:0]      res_data;
  logic [TAG_WIDTH-1:0]  res_tag;
  logic [3:0]            outstanding;
  logic                  busy;
  logic                  err;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, mem_rd_data, ready, valid_out, result,
    output cmd_ready, mem_rd_en, mem_addr, ip, valid_in, end_of_group,
           res_valid, res_data, res_tag, outstanding, busy, err
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, mem_rd_data, ready, valid_out, result,
    input  cmd_ready, mem_rd_en, mem_addr, ip, valid_in, end_of_group,
           res_valid, res_data, res_tag, outstanding, busy, err
  );
endinterface

// File: rtl/accum_group_driver.sv
// Group-input stream source for the FCBT accumulator. It accepts
// (base, len) commands, reads operands from a synchronous single-port
// memory through a 2-entry prefetch FIFO, streams them with end_of_group
// under ready backpressure, and tags the in-order results with a group
// sequence number.
module accum_group_driver #(
  parameter int WIDTH           = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_WIDTH       = 8
) (
  input logic                clk,
  input logic                rst,
  accum_group_driver_if.master bus
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  rd_pend_q, rd_last_q;
  logic [WIDTH-1:0]      fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic [3:0]            outstanding_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  res_valid_q;
  logic [WIDTH-1:0]      res_data_q;
  logic [TAG_WIDTH-1:0]  res_tag_q;
  logic                  err_q;

  logic                  cmd_ready_c, rd_issue;
  logic                  cmd_fire, cmd_start, cmd_zero;
  logic                  fifo_valid, push, pop, eog_xfer;
  logic                  res_accept, res_drop, rd_is_last, rd_room;
  logic [2:0]            pipe_fill;

  // Handshake and bookkeeping terms shared by the FSM and the datapath.
  assign cmd_fire   = bus.cmd_valid && cmd_ready_c;
  assign cmd_start  = cmd_fire && (bus.cmd_len != '0);
  assign cmd_zero   = cmd_fire && (bus.cmd_len == '0);
  assign fifo_valid = (count_q != 2'd0);
  assign push       = rd_pend_q;
  assign pop        = fifo_valid && bus.ready;
  assign eog_xfer   = pop && fifo_last[rd_ptr_q];
  assign res_accept = bus.valid_out && ((outstanding_q != 4'd0) || eog_xfer);
  assign res_drop   = bus.valid_out && !res_accept;
  assign rd_is_last = (remain_q == LEN_WIDTH'(1));
  // Entries held plus reads whose data is still coming back, less the one
  // leaving this cycle; pop implies count_q >= 1, so this cannot underflow.
  assign pipe_fill  = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_room    = (pipe_fill < 3'd2);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every register is assigned with <= so all flops sample the
    // pre-edge values together regardless of block or statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front means every path assigns
    // state_nxt, so no latch is inferred.
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start)             state_nxt = STREAM;
      STREAM:  if (rd_issue && rd_is_last) state_nxt = DRAIN;
      DRAIN:   if (eog_xfer)              state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // FSM outputs: command acceptance and memory read strobe.
  always_comb begin
    cmd_ready_c = (state_q == IDLE) && (outstanding_q < MAX_OUT) && !rst;
    rd_issue    = (state_q == STREAM) && rd_room && !rst;
  end

  // Address and remaining-read counters, plus the read-in-flight marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      remain_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      if (cmd_start) begin
        addr_q   <= bus.cmd_base;
        remain_q <= bus.cmd_len;
      end else if (rd_issue) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - LEN_WIDTH'(1);
      end
      rd_pend_q <= rd_issue;
      rd_last_q <= rd_issue && rd_is_last;
    end
  end

  // Two-entry prefetch FIFO; flushing it on reset abandons a partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is only two words, so it is reset as well; that
      // keeps ip at zero out of reset instead of showing stale data.
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr_q] <= bus.mem_rd_data;
        fifo_last[wr_ptr_q] <= rd_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outstanding-group count, tagged result register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= 4'd0;
      tag_q         <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      unique case ({eog_xfer, res_accept})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      res_valid_q <= res_accept;
      if (res_accept) begin
        res_data_q <= bus.result;
        res_tag_q  <= tag_q;
        tag_q      <= tag_q + TAG_WIDTH'(1);
      end
      if (cmd_zero || res_drop) err_q <= 1'b1;
    end
  end

  assign bus.cmd_ready    = cmd_ready_c;
  assign bus.mem_rd_en    = rd_issue;
  assign bus.mem_addr     = addr_q;
  assign bus.ip           = fifo_data[rd_ptr_q];
  assign bus.valid_in     = fifo_valid;
  assign bus.end_of_group = fifo_last[rd_ptr_q];
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.outstanding  = outstanding_q;
  assign bus.busy         = (state_q != IDLE) || (outstanding_q != 4'd0);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_accum_group_driver.sv
// Self-checking bench for accum_group_driver. Stimulus pushes expected
// beats and tagged results into queues; a negedge monitor pops and
// compares them whenever the DUT presents a beat transfer or res_valid.
module tb_accum_group_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_group_driver_if #(.WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16), .TAG_WIDTH(8)) bus ();

  accum_group_driver #(
    .WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16), .MAX_OUTSTANDING(2), .TAG_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic [7:0] tag;} res_t;

  beat_t      beat_q[$];
  res_t       res_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_tag  = 8'd0;
  logic       hold_q   = 1'b0;
  logic [31:0] hold_ip = '0;

  // Operand memory contents: one known float at 0x10, address-stamped words elsewhere.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 32'h3F80_0000 : {16'hC0DE, a};
  endfunction

  // Synchronous single-port operand memory model.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every transferred beat and every tagged result.
  always @(negedge clk) begin
    if (!rst && bus.valid_in && bus.ready) begin
      if (beat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", bus.ip);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("beat_ip", bus.ip, b.data);
        check("beat_eog", bus.end_of_group, b.last);
      end
    end
    if (hold_q) begin
      check("hold_valid", bus.valid_in, 1'b1);
      check("hold_ip", bus.ip, hold_ip);
    end
    hold_q  = !rst && bus.valid_in && !bus.ready;
    hold_ip = bus.ip;
    if (bus.res_valid) begin
      if (res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.res_data);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("res_data", bus.res_data, r.data);
        check("res_tag", bus.res_tag, r.tag);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    check({tag, "_mem_rd_en"}, bus.mem_rd_en, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, 16'h0);
    check({tag, "_valid_in"}, bus.valid_in, 1'b0);
    check({tag, "_ip"}, bus.ip, 32'h0);
    check({tag, "_eog"}, bus.end_of_group, 1'b0);
    check({tag, "_res_valid"}, bus.res_valid, 1'b0);
    check({tag, "_res_data"}, bus.res_data, 32'h0);
    check({tag, "_res_tag"}, bus.res_tag, 8'h0);
    check({tag, "_outstanding"}, bus.outstanding, 4'h0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.valid_out = 1'b0;
    step();
    step();
    check_zero("reset");
    beat_q.delete();
    res_q.delete();
    exp_tag = 8'd0;
    rst = 1'b0;
    step();
  endtask

  // Queues the group's beats, then holds cmd_valid until the handshake.
  // Returns in cycle T+1 (one cycle after the handshake cycle T).
  task automatic send_cmd(input logic [15:0] base, input logic [15:0] len);
    int n;
    for (int k = 0; k < int'(len); k++)
      beat_q.push_back('{data: mem_word(base + 16'(k)), last: (k == int'(len) - 1)});
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.cmd_ready) bound_fail("cmd_handshake");
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (beat_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (beat_q.size() != 0) bound_fail(name);
    step();
  endtask

  // One-cycle valid_out; res_valid must follow exactly one cycle later.
  task automatic send_result(input logic [31:0] data, input logic accept);
    bus.valid_out = 1'b1;
    bus.result    = data;
    if (accept) begin
      res_q.push_back('{data: data, tag: exp_tag});
      exp_tag = exp_tag + 8'd1;
    end
    step();
    bus.valid_out = 1'b0;
    check("res_latency", bus.res_valid, accept);
  endtask

  logic [15:0] addr_list [5];
  bit          pat [6];

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_base    = '0;
    bus.cmd_len     = '0;
    bus.ready       = 1'b1;
    bus.valid_out   = 1'b0;
    bus.result      = '0;
    bus.mem_rd_data = '0;
    addr_list = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    #1;
    apply_reset();

    // Single-beat group: read in T+1, beat in T+3, cmd_ready back in T+4.
    send_cmd(16'h0010, 16'd1);
    check("t1_rd_en", bus.mem_rd_en, 1'b1);
    check("t1_addr", bus.mem_addr, 16'h0010);
    step();
    step();
    check("t1_valid_t3", bus.valid_in, 1'b1);
    check("t1_ip_t3", bus.ip, 32'h3F80_0000);
    check("t1_eog_t3", bus.end_of_group, 1'b1);
    step();
    check("t1_cmd_ready_t4", bus.cmd_ready, 1'b1);
    check("t1_outstanding", bus.outstanding, 4'd1);
    send_result(32'h1111_1111, 1'b1);

    // Full-throughput group across the address wrap.
    send_cmd(16'hFFFE, 16'd5);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 5) begin
        check("t2_rd_en", bus.mem_rd_en, 1'b1);
        check("t2_addr", bus.mem_addr, addr_list[c-1]);
      end else begin
        check("t2_rd_idle", bus.mem_rd_en, 1'b0);
      end
      if (c >= 3) begin
        check("t2_valid", bus.valid_in, 1'b1);
        check("t2_eog", bus.end_of_group, c == 7);
      end
      if (c == 3) check("t2_first_ip", bus.ip, 32'hC0DE_FFFE);
      step();
    end
    check("t2_valid_after", bus.valid_in, 1'b0);
    send_result(32'h2222_2222, 1'b1);

    // Backpressure: ready follows 1,0,0,1,0,1,...
    send_cmd(16'h0100, 16'd8);
    begin
      int i;
      i = 0;
      while (beat_q.size() != 0 && i < 300) begin
        bus.ready = pat[i % 6];
        step();
        i++;
      end
      if (beat_q.size() != 0) bound_fail("t3_drain");
    end
    bus.ready = 1'b1;
    step();
    send_result(32'h3333_3333, 1'b1);

    // Outstanding limit of 2 holds off a third command until a result returns.
    apply_reset();
    send_cmd(16'h0200, 16'd3);
    wait_done("t4_grp1");
    send_cmd(16'h0210, 16'd3);
    wait_done("t4_grp2");
    check("t4_outstanding_2", bus.outstanding, 4'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = 16'h0220;
    bus.cmd_len   = 16'd3;
    for (int k = 0; k < 3; k++) begin
      check("t4_cmd_blocked", bus.cmd_ready, 1'b0);
      step();
    end
    bus.cmd_valid = 1'b0;
    send_result(32'h4040_0000, 1'b1);
    check("t4_cmd_ready_again", bus.cmd_ready, 1'b1);
    check("t4_outstanding_1", bus.outstanding, 4'd1);
    send_cmd(16'h0220, 16'd3);
    wait_done("t4_grp3");
    send_result(32'h0000_00A1, 1'b1);
    send_result(32'h0000_00A2, 1'b1);
    check("t4_outstanding_0", bus.outstanding, 4'd0);

    // Error: result with nothing outstanding is dropped.
    apply_reset();
    send_result(32'hDEAD_BEEF, 1'b0);
    check("t5_err_drop", bus.err, 1'b1);
    step();
    check("t5_err_sticky", bus.err, 1'b1);

    // Error: zero-length command is discarded; tag does not advance.
    apply_reset();
    send_cmd(16'h0500, 16'd0);
    check("t5_err_len0", bus.err, 1'b1);
    check("t5_len0_idle", bus.busy, 1'b0);
    check("t5_len0_cmd_ready", bus.cmd_ready, 1'b1);
    step();
    step();
    check("t5_len0_no_beat", bus.valid_in, 1'b0);
    send_cmd(16'h0010, 16'd1);
    wait_done("t5_after_len0");
    send_result(32'h0000_0005, 1'b1);

    // Reset after beat 4 of a 10-beat group, then a fresh len-2 group.
    send_cmd(16'h0300, 16'd10);
    for (int k = 0; k < 6; k++) step();
    rst       = 1'b1;
    bus.ready = 1'b0;
    beat_q.delete();
    step();
    check_zero("midrst");
    rst       = 1'b0;
    bus.ready = 1'b1;
    res_q.delete();
    exp_tag   = 8'd0;
    step();
    send_cmd(16'h0400, 16'd2);
    wait_done("t6_after_reset");
    send_result(32'h0000_0077, 1'b1);
    step();
    step();

    check("end_beats_left", beat_q.size(), 0);
    check("end_results_left", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
